// File: rtl/fp_add_pkg.sv
// -----------------------------------------------------------------------------
// fp_add_pkg
// Shared definitions for the single-precision FP adder pipeline.
//   - align_state_t   : state encoding of the operand alignment stage
//   - EXT_WIDTH       : width of the {mantissa, G, R, S} extended mantissa
//   - MAX_ALIGN_SHIFT : largest meaningful alignment shift
//   - sticky_rshift   : right shift in which every bit shifted past the LSB
//                       is ORed into the sticky (LSB) position
// No ports (package).
// -----------------------------------------------------------------------------
package fp_add_pkg;

    localparam int MENT_WIDTH_DEF  = 23;
    localparam int EXT_WIDTH       = MENT_WIDTH_DEF + 4;
    localparam int MAX_ALIGN_SHIFT = MENT_WIDTH_DEF + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DONE  = 2'd2
    } align_state_t;

    // Sticky right shift on a 64-bit container (callers zero-extend and
    // truncate). A k-bit shift equals k single sticky steps: the result is
    // (ext >> k) with the OR of the k discarded bits merged into bit 0.
    function automatic logic [63:0] sticky_rshift(input logic [63:0] ext,
                                                  input int unsigned amount);
        logic [63:0] lost_mask;
        logic        sticky;
        lost_mask = ~(64'hFFFF_FFFF_FFFF_FFFF << amount);
        sticky    = |(ext & lost_mask);
        return (ext >> amount) | {63'd0, sticky};
    endfunction

endpackage

// File: rtl/fp_sticky_rshift.sv
// -----------------------------------------------------------------------------
// fp_sticky_rshift
// Combinational variable-distance right shift with sticky OR-reduce of the
// discarded bits into the LSB. Used for both the per-cycle step shift and
// the single-cycle barrel alignment.
// Ports:
//   data   [WIDTH-1:0]     : value to shift ({mantissa, G, R, S})
//   amount [AMT_WIDTH-1:0] : shift distance, 0..WIDTH
//   result [WIDTH-1:0]     : shifted value with sticky preserved
// WIDTH must not exceed 64.
// -----------------------------------------------------------------------------
module fp_sticky_rshift
    import fp_add_pkg::*;
#(
    parameter int WIDTH     = EXT_WIDTH,
    parameter int AMT_WIDTH = 5
)(
    input  logic [WIDTH-1:0]     data,
    input  logic [AMT_WIDTH-1:0] amount,
    output logic [WIDTH-1:0]     result
);

    // Widen, shift with sticky, and truncate back; upper bits are always zero.
    always_comb begin
        result = WIDTH'(sticky_rshift(64'(data), 32'(amount)));
    end

endmodule

// File: rtl/addition_align_seq.sv
// -----------------------------------------------------------------------------
// addition_align_seq
// Multi-cycle operand alignment stage of the FP adder. Picks the larger
// operand ("big"), then right-shifts the smaller mantissa (extended with
// G/R/S bits) by the clamped exponent difference, SHIFT_STEP bits per cycle.
// Result is presented with a valid/ready handshake.
//
// Configuration macro: ALIGN_BARREL_SHIFT_EN
//   defined   : whole clamped shift in one ALIGN cycle (latency 2 edges)
//   undefined : iterative shift, SHIFT_STEP bits per ALIGN cycle
//   Results are bit-identical in both builds.
//
// Ports:
//   clk_in, rst_n_in            : clock, async active-low reset
//   start_valid_in / ready_out  : operand handshake (ready only in IDLE)
//   exponent_a_in, exponent_b_in: operand exponents
//   mentissa_a_in, mentissa_b_in: operand mantissas with hidden bit
//   valid_out / out_ready_in    : result handshake
//   bigger_exponent_out         : exponent of the big operand
//   big_mentissa_out            : unshifted mantissa of the big operand
//   small_mentissa_ext_out      : aligned small mantissa {mant, G, R, S}
//   swap_out                    : 1 when B is the big operand
// -----------------------------------------------------------------------------
module addition_align_seq
    import fp_add_pkg::*;
#(
    parameter int MENT_WIDTH = MENT_WIDTH_DEF,
    parameter int EXPO_WIDTH = 8,
    parameter int SHIFT_STEP = 1
)(
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    start_valid_in,
    output logic                    ready_out,
    input  logic [EXPO_WIDTH-1:0]   exponent_a_in,
    input  logic [EXPO_WIDTH-1:0]   exponent_b_in,
    input  logic [MENT_WIDTH:0]     mentissa_a_in,
    input  logic [MENT_WIDTH:0]     mentissa_b_in,
    output logic                    valid_out,
    input  logic                    out_ready_in,
    output logic [EXPO_WIDTH-1:0]   bigger_exponent_out,
    output logic [MENT_WIDTH:0]     big_mentissa_out,
    output logic [MENT_WIDTH+3:0]   small_mentissa_ext_out,
    output logic                    swap_out
);

    localparam int EXT_W  = MENT_WIDTH + 4;
    localparam int CNT_W  = $clog2(EXT_W + 1);
    localparam int DIFF_W = EXPO_WIDTH + 1;
    localparam logic [CNT_W-1:0]  MAX_SHIFT_C = CNT_W'(EXT_W);
    localparam logic [DIFF_W-1:0] MAX_DIFF_C  = DIFF_W'(EXT_W);

    align_state_t       state_r;
    logic [CNT_W-1:0]   remaining_r;

    logic               a_big_s;
    logic [DIFF_W-1:0]  diff_s;
    logic [CNT_W-1:0]   shift_init_s;
    logic [CNT_W-1:0]   step_s;
    logic [EXT_W-1:0]   shifted_s;

    // Big-operand selection and saturated exponent distance for the accept.
    always_comb begin
        a_big_s      = 1'b0;
        diff_s       = '0;
        shift_init_s = '0;
        if (exponent_a_in > exponent_b_in) begin
            a_big_s = 1'b1;
        end else if ((exponent_a_in == exponent_b_in) &&
                     (mentissa_a_in >= mentissa_b_in)) begin
            a_big_s = 1'b1;
        end else begin
            a_big_s = 1'b0;
        end
        // Difference taken after selection, one bit wider: never negative.
        if (a_big_s) begin
            diff_s = {1'b0, exponent_a_in} - {1'b0, exponent_b_in};
        end else begin
            diff_s = {1'b0, exponent_b_in} - {1'b0, exponent_a_in};
        end
        // Beyond EXT_W every bit ends up in sticky anyway.
        if (diff_s >= MAX_DIFF_C) begin
            shift_init_s = MAX_SHIFT_C;
        end else begin
            shift_init_s = CNT_W'(diff_s);
        end
    end

    // Shift distance applied in the current ALIGN cycle.
    always_comb begin
        step_s = '0;
`ifdef ALIGN_BARREL_SHIFT_EN
        step_s = remaining_r;
`else
        if (remaining_r > CNT_W'(SHIFT_STEP)) begin
            step_s = CNT_W'(SHIFT_STEP);
        end else begin
            step_s = remaining_r;
        end
`endif
    end

    fp_sticky_rshift #(
        .WIDTH     (EXT_W),
        .AMT_WIDTH (CNT_W)
    ) u_shift (
        .data   (small_mentissa_ext_out),
        .amount (step_s),
        .result (shifted_s)
    );

    // Alignment FSM with registered handshake and data outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r                <= IDLE;
            remaining_r            <= '0;
            ready_out              <= 1'b1;
            valid_out              <= 1'b0;
            bigger_exponent_out    <= '0;
            big_mentissa_out       <= '0;
            small_mentissa_ext_out <= '0;
            swap_out               <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid_in) begin
                        swap_out <= ~a_big_s;
                        if (a_big_s) begin
                            bigger_exponent_out    <= exponent_a_in;
                            big_mentissa_out       <= mentissa_a_in;
                            small_mentissa_ext_out <= {mentissa_b_in, 3'b000};
                        end else begin
                            bigger_exponent_out    <= exponent_b_in;
                            big_mentissa_out       <= mentissa_b_in;
                            small_mentissa_ext_out <= {mentissa_a_in, 3'b000};
                        end
                        remaining_r <= shift_init_s;
                        ready_out   <= 1'b0;
                        state_r     <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (remaining_r == '0) begin
                        valid_out <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        small_mentissa_ext_out <= shifted_s;
                        remaining_r            <= remaining_r - step_s;
                        // Last step: finish on the same edge.
                        if (remaining_r == step_s) begin
                            valid_out <= 1'b1;
                            state_r   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_in) begin
                        valid_out <= 1'b0;
                        ready_out <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    remaining_r <= '0;
                    ready_out   <= 1'b1;
                    valid_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule
